// File: rtl/sir_pkg.sv
// Shared encodings and elaboration-time helpers for the SIR epidemic grid.
package sir_pkg;

  localparam logic [1:0] ST_S = 2'b00;
  localparam logic [1:0] ST_I = 2'b01;
  localparam logic [1:0] ST_R = 2'b10;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_STEP,
    FSM_SETTLE,
    FSM_DONE
  } fsmState_t;

  // Neighbour k (0..7) walks the 3x3 window row-major, skipping the centre.
  // Returns the neighbour's address, or -1 when it falls off a non-wrapping edge.
  function automatic int nbrIndex(input int row, input int col, input int k,
                                  input int nx, input int ny, input int wrap);
    int idx;
    int r;
    int c;
    idx = (k < 4) ? k : k + 1;
    r   = row + idx / 3 - 1;
    c   = col + idx % 3 - 1;
    if (wrap != 0) begin
      r = (r + ny) % ny;
      c = (c + nx) % nx;
    end else if (r < 0 || r >= ny || c < 0 || c >= nx) begin
      return -1;
    end
    return r * nx + c;
  endfunction

  // An all-zero LFSR would lock up, so that seed is bumped to 1.
  function automatic logic [15:0] cellSeed(input logic [15:0] base, input int addr);
    logic [15:0] s;
    s = base + 16'(addr);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/sir_cell.sv
// One SIR cell: 2-bit state, infection-day counter and a private Galois LFSR.
module sir_cell
  import sir_pkg::*;
#(
  parameter int          INF_DAYS  = 4,
  parameter logic [15:0] CELL_SEED = 16'h0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       load,
  input  logic [1:0] initVal,
  input  logic [7:0] nbrInf,
  input  logic [8:0] prob,
  output logic [1:0] state
);

  localparam logic [7:0] LAST_DAY = 8'(INF_DAYS - 1);

  logic [7:0]  day;
  logic [15:0] lfsr;
  logic [15:0] lfsrNext;
  logic [3:0]  nInf;
  logic [11:0] threshold;
  logic        infect;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nInf = '0;
    for (int k = 0; k < 8; k++) begin
      nInf = nInf + {3'b000, nbrInf[k]};
    end
    threshold = {8'h00, nInf} * {3'b000, prob};
    infect    = (nInf != 4'd0) && ({4'h0, lfsr[7:0]} < threshold);
    lfsrNext  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
  end

  // NOTE: state registers use non-blocking assignments so all cells sample pre-step neighbour states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_S;
      day   <= '0;
      lfsr  <= CELL_SEED;
    end else if (load) begin
      state <= (initVal == 2'b11) ? ST_R : initVal;
      day   <= '0;
      lfsr  <= CELL_SEED;
    end else if (step) begin
      lfsr <= lfsrNext;
      case (state)
        ST_S: begin
          day <= '0;
          if (infect) state <= ST_I;
        end
        ST_I: begin
          if (day == LAST_DAY) begin
            state <= ST_R;
            day   <= '0;
          end else begin
            day <= day + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sir_grid.sv
// X-by-Y SIR grid: cell array, neighbour wiring, infected popcount and step-run controller.
module sir_grid
  import sir_pkg::*;
#(
  parameter  int          X        = 4,
  parameter  int          Y        = 4,
  parameter  int          WRAP     = 0,
  parameter  int          INF_DAYS = 4,
  parameter  logic [15:0] SEED     = 16'hACE1,
  localparam int          N        = X * Y,
  localparam int          CW       = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*N-1:0]  init_state,
  input  logic            load_state,
  input  logic            start,
  input  logic [15:0]     num_steps,
  input  logic [8:0]      prob,
  output logic [2*N-1:0]  states,
  output logic            busy,
  output logic            done,
  output logic [15:0]     step_count,
  output logic [CW-1:0]   infected_count
);

  fsmState_t   fsmQ;
  fsmState_t   fsmD;
  logic [15:0] stepLimit;
  logic [N-1:0] isInf;
  logic [CW-1:0] popNow;
  logic        idleOrDone;
  logic        loadPulse;
  logic        startPulse;
  logic        stepPulse;

  for (genvar i = 0; i < Y; i++) begin : gRow
    for (genvar j = 0; j < X; j++) begin : gCol
      localparam int A = i * X + j;
      logic [7:0] nbr;

      for (genvar k = 0; k < 8; k++) begin : gNbr
        localparam int NA = nbrIndex(i, j, k, X, Y, WRAP);
        if (NA >= 0) begin : gHit
          assign nbr[k] = isInf[NA];
        end else begin : gMiss
          assign nbr[k] = 1'b0;
        end
      end

      sir_cell #(
        .INF_DAYS (INF_DAYS),
        .CELL_SEED(cellSeed(SEED, A))
      ) uCell (
        .clk    (clk),
        .rst    (rst),
        .step   (stepPulse),
        .load   (loadPulse),
        .initVal(init_state[2*A+1 -: 2]),
        .nbrInf (nbr),
        .prob   (prob),
        .state  (states[2*A+1 -: 2])
      );

      assign isInf[A] = (states[2*A+1 -: 2] == ST_I);
    end
  end

  always_comb begin
    popNow = '0;
    for (int a = 0; a < N; a++) begin
      popNow = popNow + CW'(isInf[a]);
    end
  end

  // Load beats start when both arrive together.
  assign idleOrDone = (fsmQ == FSM_IDLE) || (fsmQ == FSM_DONE);
  assign loadPulse  = load_state && idleOrDone;
  assign startPulse = start && !load_state && idleOrDone;
  assign stepPulse  = (fsmQ == FSM_STEP);
  assign busy       = (fsmQ == FSM_STEP) || (fsmQ == FSM_SETTLE);
  assign done       = (fsmQ == FSM_DONE);

  // The termination test uses the live popcount, i.e. the post-step value being registered this cycle.
  always_comb begin
    fsmD = fsmQ;
    case (fsmQ)
      FSM_IDLE, FSM_DONE: begin
        if (loadPulse)       fsmD = FSM_IDLE;
        else if (startPulse) fsmD = (num_steps == 16'd0) ? FSM_DONE : FSM_STEP;
      end
      FSM_STEP:   fsmD = FSM_SETTLE;
      FSM_SETTLE: fsmD = ((step_count == stepLimit) || (popNow == '0)) ? FSM_DONE : FSM_STEP;
      default:    fsmD = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsmQ           <= FSM_IDLE;
      step_count     <= '0;
      stepLimit      <= '0;
      infected_count <= '0;
    end else begin
      fsmQ           <= fsmD;
      infected_count <= popNow;
      if (loadPulse) begin
        step_count <= '0;
      end else if (startPulse) begin
        step_count <= '0;
        stepLimit  <= num_steps;
      end else if (stepPulse) begin
        step_count <= step_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sir_grid.sv
// Directed bench for sir_grid: three instances (plain, torus, 3-day) on shared stimulus.
module tb_sir_grid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] init_state = '0;
  logic        load_state = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_steps = '0;
  logic [8:0]  prob = '0;

  logic [31:0] statesA, statesB, statesC;
  logic        busyA, busyB, busyC;
  logic        doneA, doneB, doneC;
  logic [15:0] scA, scB, scC;
  logic [4:0]  icA, icB, icC;

  int vectors = 0;
  int miscompares = 0;
  int cycles;

  always #5 clk = ~clk;

  sir_grid #(.X(4), .Y(4), .WRAP(0), .INF_DAYS(2)) dutA (
    .clk(clk), .rst(rst), .init_state(init_state), .load_state(load_state),
    .start(start), .num_steps(num_steps), .prob(prob), .states(statesA),
    .busy(busyA), .done(doneA), .step_count(scA), .infected_count(icA)
  );

  sir_grid #(.X(4), .Y(4), .WRAP(1), .INF_DAYS(4)) dutB (
    .clk(clk), .rst(rst), .init_state(init_state), .load_state(load_state),
    .start(start), .num_steps(num_steps), .prob(prob), .states(statesB),
    .busy(busyB), .done(doneB), .step_count(scB), .infected_count(icB)
  );

  sir_grid #(.X(4), .Y(4), .WRAP(0), .INF_DAYS(3)) dutC (
    .clk(clk), .rst(rst), .init_state(init_state), .load_state(load_state),
    .start(start), .num_steps(num_steps), .prob(prob), .states(statesC),
    .busy(busyC), .done(doneC), .step_count(scC), .infected_count(icC)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held for two cycles.
    rst = 1'b1;
    tick();
    tick();
    check("rst_states", statesA, 32'h0);
    check("rst_busy", busyA, 1'b0);
    check("rst_done", doneA, 1'b0);
    check("rst_step_count", scA, 16'd0);
    check("rst_infected", icA, 5'd0);
    rst = 1'b0;

    // Certain spread from cell 0, one step.
    init_state = 32'h0000_0001;
    load_state = 1'b1;
    tick();
    load_state = 1'b0;
    check("load_states", statesA, 32'h0000_0001);
    num_steps = 16'd1;
    prob      = 9'd256;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("spread_busy", busyA, 1'b1);
    tick();
    check("spread_states", statesA, 32'h0000_0505);
    check("spread_step_count", scA, 16'd1);
    check("spread_not_done_yet", doneA, 1'b0);
    tick();
    check("spread_done", doneA, 1'b1);
    check("spread_infected", icA, 5'd4);
    check("torus_states", statesB, 32'h4500_4545);
    check("torus_infected", icB, 5'd9);

    // Extinction: cell 5 infected, no spread, 3-day illness.
    init_state = 32'h0000_0400;
    load_state = 1'b1;
    tick();
    load_state = 1'b0;
    check("ext_load_clears_done", doneC, 1'b0);
    num_steps = 16'd100;
    prob      = 9'd0;
    start     = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 0;
    while (!doneC && cycles < 50) begin
      tick();
      cycles++;
    end
    check("ext_done", doneC, 1'b1);
    check("ext_cycles", cycles, 6);
    check("ext_step_count", scC, 16'd3);
    check("ext_infected", icC, 5'd0);
    check("ext_states", statesC, 32'h0000_0800);

    // Zero-step run finishes on the next cycle with states untouched.
    init_state = 32'h0000_0001;
    load_state = 1'b1;
    tick();
    load_state = 1'b0;
    check("zero_idle_done", doneA, 1'b0);
    num_steps = 16'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", doneA, 1'b1);
    check("zero_busy", busyA, 1'b0);
    check("zero_states", statesA, 32'h0000_0001);
    check("zero_step_count", scA, 16'd0);

    // Load and start together: load only, code 11 stored as 10.
    load_state = 1'b1;
    tick();
    load_state = 1'b0;
    init_state = 32'hC000_0001;
    num_steps  = 16'd5;
    prob       = 9'd256;
    load_state = 1'b1;
    start      = 1'b1;
    tick();
    load_state = 1'b0;
    start      = 1'b0;
    check("both_states", statesA, 32'h8000_0001);
    check("both_busy", busyA, 1'b0);
    tick();
    check("both_still_idle", busyA, 1'b0);
    check("both_not_done", doneA, 1'b0);

    // Load during STEP is ignored.
    start = 1'b1;
    tick();
    start      = 1'b0;
    init_state = 32'h0;
    load_state = 1'b1;
    tick();
    load_state = 1'b0;
    check("busy_load_ignored", statesA, 32'h8000_0505);
    check("busy_load_busy", busyA, 1'b1);

    // Reset during SETTLE of step 2.
    tick();
    tick();
    check("mid_states_step2", statesA, 32'h8015_1516);
    check("mid_step_count", scA, 16'd2);
    check("mid_busy", busyA, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_states", statesA, 32'h0);
    check("mid_rst_busy", busyA, 1'b0);
    check("mid_rst_done", doneA, 1'b0);
    check("mid_rst_step_count", scA, 16'd0);
    check("mid_rst_infected", icA, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
